// File: rtl/pcounter_pkg.sv
// Shared types for the pcounter increment scheduler.
//   DATA_W         : default operand/result width
//   sched_state_t  : scheduler FSM state encoding
//   word_t         : operand/result word at the default width
package pcounter_pkg;

  localparam int unsigned DATA_W = 40;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } sched_state_t;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/pcounter_rr_arb.sv
// Round-robin arbiter, purely combinational.
// Picks the first valid requester at or above ptr, wrapping modulo NUM_REQ.
// Ports:
//   req_valid : per-requester valid
//   ptr       : highest-priority index for this round
//   grant     : one-hot grant (all zero when nothing is valid)
//   grant_id  : encoded index of the granted requester
module pcounter_rr_arb #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic              found;
  int unsigned       sum;
  logic [ID_W-1:0]   idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    sum      = 0;
    idx      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = ID_W'(sum);
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/pcounter_sched.sv
// Shares one increment datapath among NUM_REQ requesters.
// A round-robin grant captures one operand, EXEC computes operand+1, and
// RESP presents the result tagged with the owner's id until accepted.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   req_valid   : per-requester operand valid
//   req_data    : packed operands, requester i at [i*DATA_W +: DATA_W]
//   req_ready   : one-hot accept, only asserted in IDLE
//   resp_valid  : result available (RESP state)
//   resp_ready  : consumer accepts result
//   resp_data   : operand+1 modulo 2^DATA_W
//   resp_id     : requester that owns resp_data
//   resp_wrap   : operand was all ones
//   busy        : FSM not in IDLE
//   op_count    : completed responses, saturating
module pcounter_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = pcounter_pkg::DATA_W,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_W-1:0]         resp_data,
  output logic [ID_W-1:0]           resp_id,
  output logic                      resp_wrap,
  output logic                      busy,
  output logic [CNT_W-1:0]          op_count
);

  import pcounter_pkg::*;

  sched_state_t        state, state_next;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     ptr_next;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic [DATA_W-1:0]   sel_data;
  logic [DATA_W-1:0]   operand;
  logic [ID_W-1:0]     id_q;

  pcounter_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_id  (grant_id)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    if (grant_id == ID_W'(NUM_REQ - 1)) ptr_next = '0;
    else                                ptr_next = grant_id + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    resp_valid = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = grant;
        if (|req_valid) state_next = EXEC;
      end
      EXEC: begin
        busy       = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      operand   <= '0;
      id_q      <= '0;
      resp_data <= '0;
      resp_id   <= '0;
      resp_wrap <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            operand <= sel_data;
            id_q    <= grant_id;
            ptr     <= ptr_next;
          end
        end
        EXEC: begin
          resp_data <= operand + DATA_W'(1);
          resp_wrap <= &operand;
          resp_id   <= id_q;
        end
        RESP: begin
          if (resp_ready && !(&op_count)) op_count <= op_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
